// File: rtl/gen_block_queue.sv
// gen_block_queue: LFSR-driven tetromino generator with a 7-bag or uniform
// rejection sampler, feeding a head + preview shift-register queue.

package gen_block_queue_pkg;
   typedef struct packed {
      logic [63:0] data;      // 4 rotations x 4 rows x 4 bits, rot r at [16r +: 16], row n at [4n +: 4]
      logic [2:0]  color;
      logic [1:0]  rotation;
      logic [3:0]  x;
      logic [4:0]  y;
   } block_info_t;
endpackage

module gen_block_queue
   import gen_block_queue_pkg::*;
#(
   parameter int unsigned PREVIEW_DEPTH   = 3,
   parameter int unsigned LFSR_W          = 15,
   parameter int unsigned SEED            = 1,
   parameter bit          BAG_MODE        = 1'b1,
   parameter bit          RANDOM_ROTATION = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         take_i,
   output logic                         valid_o,
   output logic                         full_o,
   output block_info_t                  next_block_o,
   output logic [PREVIEW_DEPTH*3-1:0]   preview_types_o
);

   localparam int unsigned       SLOTS     = PREVIEW_DEPTH + 1;
   localparam int unsigned       CW        = $clog2(PREVIEW_DEPTH + 2);
   localparam logic [CW-1:0]     FULL_CNT  = CW'(SLOTS);
   localparam int unsigned       TAP_B     = (LFSR_W == 31) ? 27 : 13;
   localparam logic [LFSR_W-1:0] SEED_RAW  = LFSR_W'(SEED);
   localparam logic [LFSR_W-1:0] SEED_INIT = (SEED_RAW == '0) ? LFSR_W'(1) : SEED_RAW;

   typedef struct packed {
      logic [2:0] typ;
      logic [1:0] rot;
   } entry_t;

   typedef enum logic {ST_FILL, ST_READY} state_e;

   // Shape bitmaps indexed by piece type (I J L O S T Z).
   function automatic logic [63:0] shape(input logic [2:0] t);
      case (t)
         3'd0:    shape = 64'h4444_0F00_2222_00F0;
         3'd1:    shape = 64'h0C44_02E0_0446_00E8;
         3'd2:    shape = 64'h044C_08E0_0644_00E2;
         3'd3:    shape = 64'h0066_0066_0066_0066;
         3'd4:    shape = 64'h04C8_0C60_0264_00C6;
         3'd5:    shape = 64'h04C4_04E0_0464_00E4;
         3'd6:    shape = 64'h08C4_06C0_0462_006C;
         default: shape = '0;
      endcase
   endfunction

   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [6:0]        bag_q, bag_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   entry_t            queue_q [SLOTS];
   entry_t            queue_d [SLOTS];
   state_e            state_q, state_d;

   logic              pop;
   logic              accept;
   logic [CW-1:0]     cnt_post;
   logic [2:0]        cand;
   logic [1:0]        crot;
   logic [7:0]        cand_onehot;
   logic [6:0]        bag_set;

   // Sampler, queue and bag next-state; acceptance uses the post-pop count.
   always_comb begin
      pop         = take_i && (cnt_q != '0);
      cnt_post    = cnt_q - CW'(pop);
      cand        = lfsr_q[2:0];
      crot        = RANDOM_ROTATION ? lfsr_q[4:3] : 2'b00;
      cand_onehot = 8'b1 << cand;
      accept      = (cand != 3'd7) && (cnt_post < FULL_CNT) &&
                    (!BAG_MODE || ((bag_q & cand_onehot[6:0]) == '0));

      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1] ^ lfsr_q[TAP_B]};

      bag_set = bag_q | cand_onehot[6:0];
      bag_d   = bag_q;
      if (accept && BAG_MODE) begin
         bag_d = (bag_set == '1) ? '0 : bag_set;
      end

      queue_d = queue_q;
      if (pop) begin
         for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
            queue_d[i] = queue_q[i+1];
         end
         queue_d[PREVIEW_DEPTH] = '0;
      end
      if (accept) begin
         for (int unsigned i = 0; i < SLOTS; i++) begin
            if (CW'(i) == cnt_post) begin
               queue_d[i] = '{typ: cand, rot: crot};
            end
         end
      end

      cnt_d = cnt_post + CW'(accept);
   end

   // Status FSM: READY exactly while the queue is full.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL:  if (accept && (cnt_d == FULL_CNT)) state_d = ST_READY;
         ST_READY: if (pop && !accept)                state_d = ST_FILL;
         default:  state_d = ST_FILL;
      endcase
   end

   // State registers with synchronous reset overriding pop and push.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lfsr_q  <= SEED_INIT;
         bag_q   <= '0;
         cnt_q   <= '0;
         queue_q <= '{default: '0};
         state_q <= ST_FILL;
      end else begin
         lfsr_q  <= lfsr_d;
         bag_q   <= bag_d;
         cnt_q   <= cnt_d;
         queue_q <= queue_d;
         state_q <= state_d;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      valid_o               = (cnt_q != '0);
      full_o                = (state_q == ST_READY);
      next_block_o.data     = valid_o ? shape(queue_q[0].typ) : '0;
      next_block_o.color    = valid_o ? (queue_q[0].typ + 3'd1) : '0;
      next_block_o.rotation = queue_q[0].rot;
      next_block_o.x        = 4'd4;
      next_block_o.y        = '0;
      preview_types_o       = '1;
      for (int unsigned i = 0; i < PREVIEW_DEPTH; i++) begin
         if (CW'(i + 1) < cnt_q) begin
            preview_types_o[3*i +: 3] = queue_q[i+1].typ;
         end
      end
   end

endmodule
